fsm_prog_loader: RTL and testbench

- Writer side of the programmable FSM controller's table-programming port.
- Accepts table bytes from an asynchronous host over pins: 8-bit data plus a toggle strobe.
- Frames and validates them, then emits one single-cycle write strobe per table byte, with byte address and data, toward the controller.
- Sits between the top-level bidirectional-IO inputs and the controller's programming inputs.

---
 rtl/fsm_prog_loader.sv | 154 +++++++++++++++
 tb/tb_fsm_prog_loader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_prog_loader.sv
// Table-programming writer: synchronises a toggle-strobed host byte stream,
// frames it (header, TABLE_BYTES body bytes, XOR checksum) and emits write strobes.
module fsm_prog_loader #(
    parameter int         TABLE_BYTES    = 128,
    parameter int         ADDR_WIDTH     = $clog2(TABLE_BYTES),
    parameter logic [7:0] HEADER         = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            host_data,
    input  logic                  host_strobe,
    output logic                  prog_enable,
    output logic [ADDR_WIDTH-1:0] prog_addr,
    output logic [7:0]            prog_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    // state | meaning
    // IDLE  | waiting for HEADER; other bytes ignored
    // BODY  | writing table bytes 0..TABLE_BYTES-1
    // CHECK | waiting for the checksum byte
    typedef enum logic [1:0] {IDLE, BODY, CHECK} state_t;

    localparam int                    CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TABLE_BYTES - 1);
    localparam logic [CNT_W-1:0]      TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                state, state_next;
    logic                  sync1, sync2, prev;
    logic                  event_q;
    logic [7:0]            byte_q;
    logic [7:0]            checksum, sum_next;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic                  en_next, done_next, error_next;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [7:0]            data_next;
    logic                  strobe_event;
    logic                  timeout_hit;

    assign strobe_event = sync2 ^ prev;
    assign busy         = (state != IDLE);
    // Fires on the cycle the counter would reach TIMEOUT_CYCLES; a byte event takes priority.
    assign timeout_hit  = (state != IDLE) && !event_q && (cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            prev    <= 1'b0;
            event_q <= 1'b0;
            byte_q  <= 8'h00;
        end else begin
            sync1   <= host_strobe;
            sync2   <= sync1;
            prev    <= sync2;
            event_q <= strobe_event;
            if (strobe_event) begin
                byte_q <= host_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            prog_enable <= 1'b0;
            prog_addr   <= '0;
            prog_data   <= 8'h00;
            done        <= 1'b0;
            error       <= 1'b0;
            checksum    <= 8'h00;
            cnt         <= '0;
        end else begin
            state       <= state_next;
            prog_enable <= en_next;
            prog_addr   <= addr_next;
            prog_data   <= data_next;
            done        <= done_next;
            error       <= error_next;
            checksum    <= sum_next;
            cnt         <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        en_next    = 1'b0;
        addr_next  = prog_addr;
        data_next  = prog_data;
        done_next  = done;
        error_next = error;
        sum_next   = checksum;
        cnt_next   = cnt;

        // Address advances the cycle after each write pulse, wrapping at the table end.
        if (prog_enable) begin
            addr_next = (prog_addr == LAST_ADDR) ? '0 : prog_addr + ADDR_WIDTH'(1);
        end

        if (timeout_hit) begin
            state_next = IDLE;
            error_next = 1'b1;
            done_next  = 1'b0;
            addr_next  = '0;
            cnt_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_next = '0;
                    if (event_q && (byte_q == HEADER)) begin
                        state_next = BODY;
                        done_next  = 1'b0;
                        error_next = 1'b0;
                        sum_next   = 8'h00;
                        addr_next  = '0;
                    end
                end
                BODY: begin
                    if (event_q) begin
                        cnt_next  = '0;
                        en_next   = 1'b1;
                        data_next = byte_q;
                        sum_next  = checksum ^ byte_q;
                        if (prog_addr == LAST_ADDR) begin
                            state_next = CHECK;
                        end
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                CHECK: begin
                    if (event_q) begin
                        cnt_next   = '0;
                        state_next = IDLE;
                        if (byte_q == checksum) begin
                            done_next = 1'b1;
                        end else begin
                            error_next = 1'b1;
                        end
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_prog_loader.sv
// Directed bench for fsm_prog_loader with TABLE_BYTES=4 and TIMEOUT_CYCLES=20;
// host toggles are spaced 8 clk cycles apart.
module tb_fsm_prog_loader;

    logic       clk;
    logic       rst_n;
    logic [7:0] host_data;
    logic       host_strobe;
    logic       prog_enable;
    logic [1:0] prog_addr;
    logic [7:0] prog_data;
    logic       busy;
    logic       done;
    logic       error;

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt = 0;

    typedef struct {
        logic [7:0] data;
        logic       pulse;
        logic [1:0] addr;
        logic [7:0] pdata;
        logic       busy;
        logic       done;
        logic       error;
    } vec_t;

    vec_t vecs[20];

    fsm_prog_loader #(
        .TABLE_BYTES   (4),
        .HEADER        (8'hA5),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .host_data  (host_data),
        .host_strobe(host_strobe),
        .prog_enable(prog_enable),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            if (prog_enable) pulse_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Toggles the strobe, verifies no pulse before the third edge after first sampling,
    // and returns 1ns after that third edge (where the byte's effect must be visible).
    task automatic strobe_byte(input logic [7:0] b);
        @(negedge clk);
        host_data   = b;
        host_strobe = ~host_strobe;
        repeat (3) @(posedge clk);
        #1;
        check("early_pulse", prog_enable, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
    endtask

    task automatic check_pulse(input logic [1:0] a, input logic [7:0] d);
        check("pulse_en", prog_enable, 1'b1);
        check("pulse_addr", prog_addr, a);
        check("pulse_data", prog_data, d);
    endtask

    initial begin
        int base;

        vecs[0]  = '{8'h5A, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{8'hA5, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{8'h11, 1'b1, 2'd0, 8'h11, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{8'h22, 1'b1, 2'd1, 8'h22, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{8'h33, 1'b1, 2'd2, 8'h33, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{8'h44, 1'b1, 2'd3, 8'h44, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{8'h44, 1'b0, 2'd0, 8'h44, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{8'h5A, 1'b0, 2'd0, 8'h44, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{8'hA5, 1'b0, 2'd0, 8'h44, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{8'h01, 1'b1, 2'd0, 8'h01, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{8'h02, 1'b1, 2'd1, 8'h02, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{8'h03, 1'b1, 2'd2, 8'h03, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{8'h04, 1'b1, 2'd3, 8'h04, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{8'h00, 1'b0, 2'd0, 8'h04, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{8'hA5, 1'b0, 2'd0, 8'h04, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{8'h11, 1'b1, 2'd0, 8'h11, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{8'h22, 1'b1, 2'd1, 8'h22, 1'b1, 1'b0, 1'b0};
        vecs[17] = '{8'h33, 1'b1, 2'd2, 8'h33, 1'b1, 1'b0, 1'b0};
        vecs[18] = '{8'h44, 1'b1, 2'd3, 8'h44, 1'b1, 1'b0, 1'b0};
        vecs[19] = '{8'h44, 1'b0, 2'd0, 8'h44, 1'b0, 1'b1, 1'b0};

        rst_n       = 1'b0;
        host_strobe = 1'b0;
        host_data   = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_en", prog_enable, 1'b0);
        check("rst_addr", prog_addr, 2'd0);
        check("rst_data", prog_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Good frame, noise byte, bad frame, then a good frame that clears error.
        for (int i = 0; i < 20; i++) begin
            strobe_byte(vecs[i].data);
            check($sformatf("v%0d_en", i), prog_enable, vecs[i].pulse);
            check($sformatf("v%0d_addr", i), prog_addr, vecs[i].addr);
            check($sformatf("v%0d_data", i), prog_data, vecs[i].pdata);
            check($sformatf("v%0d_busy", i), busy, vecs[i].busy);
            check($sformatf("v%0d_done", i), done, vecs[i].done);
            check($sformatf("v%0d_error", i), error, vecs[i].error);
            settle();
        end
        check("table_pulse_count", pulse_cnt, 12);

        // Timeout: error rises exactly 20 edges after the last processed byte.
        base = pulse_cnt;
        strobe_byte(8'hA5);
        check("to_busy", busy, 1'b1);
        settle();
        strobe_byte(8'h11);
        check_pulse(2'd0, 8'h11);
        settle();
        strobe_byte(8'h22);
        check_pulse(2'd1, 8'h22);
        settle();
        repeat (15) @(posedge clk);
        #1;
        check("to_error_early", error, 1'b0);
        check("to_busy_early", busy, 1'b1);
        @(posedge clk);
        #1;
        check("to_error", error, 1'b1);
        check("to_done", done, 1'b0);
        check("to_busy", busy, 1'b0);
        check("to_addr", prog_addr, 2'd0);
        check("to_pulse_count", pulse_cnt - base, 2);

        // Byte event on the same cycle the counter would expire: the byte wins.
        strobe_byte(8'hA5);
        check("sim_error_clr", error, 1'b0);
        settle();
        strobe_byte(8'h11);
        check_pulse(2'd0, 8'h11);
        settle();
        repeat (12) @(posedge clk);
        strobe_byte(8'h22);
        check_pulse(2'd1, 8'h22);
        check("sim_error", error, 1'b0);
        check("sim_busy", busy, 1'b1);
        settle();
        repeat (15) @(posedge clk);
        #1;
        check("sim_restart_early", error, 1'b0);
        @(posedge clk);
        #1;
        check("sim_restart_error", error, 1'b1);

        // Reset mid-frame: everything clears and a fresh header is required.
        strobe_byte(8'hA5);
        settle();
        strobe_byte(8'h11);
        check_pulse(2'd0, 8'h11);
        settle();
        @(negedge clk);
        rst_n       = 1'b0;
        host_strobe = 1'b0;
        #1;
        check("mrst_en", prog_enable, 1'b0);
        check("mrst_addr", prog_addr, 2'd0);
        check("mrst_data", prog_data, 8'h00);
        check("mrst_busy", busy, 1'b0);
        check("mrst_done", done, 1'b0);
        check("mrst_error", error, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        base = pulse_cnt;
        strobe_byte(8'h22);
        check("mrst_b22_busy", busy, 1'b0);
        settle();
        strobe_byte(8'h33);
        check("mrst_b33_busy", busy, 1'b0);
        settle();
        check("mrst_no_pulse", pulse_cnt - base, 0);
        strobe_byte(8'hA5);
        check("mrst_hdr_busy", busy, 1'b1);
        settle();
        strobe_byte(8'h44);
        check_pulse(2'd0, 8'h44);
        settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
